// File: rtl/alu_sequencer.sv
// Collects opcode, A and B words from a valid/ready stream, runs one external-ALU cycle, presents the result.
// Latency: one edge from the B-word transfer to out_valid; best case one result every 5 cycles.
// Backpressure: in_ready drops from EXEC until the result is taken; HOLD waits for out_ready, no bypass.
module alu_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_control,
    input  logic [N-1:0] alu_result,
    output logic [N-1:0] out_data,
    output logic [2:0]   out_op,
    output logic         out_err,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  op_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        HOLD
    } state_t;

    localparam logic [2:0] OP_UNDEF = 3'b011;

    state_t state;
    logic   in_xfer;
    logic   op_undef;

    assign in_xfer  = in_valid && in_ready;
    assign op_undef = (alu_control == OP_UNDEF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            out_data    <= '0;
            out_op      <= '0;
            out_err     <= 1'b0;
            out_valid   <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        alu_control <= in_data[2:0];
                        state       <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (in_xfer) begin
                        alu_a <= in_data;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        alu_b    <= in_data;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU floats its result for the undefined opcode, so never sample it then.
                    out_data  <= op_undef ? '0 : alu_result;
                    out_op    <= alu_control;
                    out_err   <= op_undef;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
